// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch requester (I, read-only) and a data
// requester (D, read/write) onto one shared memory port. At most one
// transaction is in flight. FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin on conflict (last_owner bit, reset to I)
//   undefined : fixed priority, D wins on conflict
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   i_req/i_addr          : I request and address
//   i_ack/i_rdata         : I one-cycle acknowledge, held read data
//   d_req/d_we/d_addr     : D request, write enable and address
//   d_wd/d_wmask          : D write data and byte mask
//   d_ack/d_rdata         : D one-cycle acknowledge, held read data
//   mem_req/mem_we/mem_a  : shared port request, write enable, address
//   mem_wd/mem_wmask      : shared port write data and byte mask
//   mem_gnt               : memory accepted the request (ISSUE only)
//   mem_rvalid/mem_rd     : completion and read data (WAIT only)
//   busy                  : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wd,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_a,
  output logic [DATA_W-1:0]   mem_wd,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rd,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_req_q, i_ack_q, d_ack_q, busy_q;
  logic                sel_d_s;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // Round-robin pick: on conflict the port that did not win last time wins.
  always_comb begin
    sel_d_s = d_req && (!i_req || (last_owner_q == OWN_I));
  end
`else
  // Fixed priority pick: D wins whenever it requests.
  always_comb begin
    sel_d_s = d_req;
  end
`endif

  // Next-state and datapath latch logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    wmask_d   = wmask_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
          last_owner_d = sel_d_s ? OWN_D : OWN_I;
`endif
          if (sel_d_s) begin
            owner_d = OWN_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wd_d    = d_wd;
            wmask_d = d_wmask;
          end else begin
            // I port is read-only: never a write, never a byte mask.
            owner_d = OWN_I;
            we_d    = 1'b0;
            addr_d  = i_addr;
            wd_d    = '0;
            wmask_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // Writes complete on rvalid too; the returned data is stored anyway.
        if (mem_rvalid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rd;
          end else begin
            i_rdata_d = mem_rd;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from state_d
  // so that they are registered and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      wmask_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_req_q <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      wmask_q   <= wmask_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      mem_req_q <= (state_d == ST_ISSUE);
      i_ack_q   <= (state_d == ST_RESP) && (owner_d == OWN_I);
      d_ack_q   <= (state_d == ST_RESP) && (owner_d == OWN_D);
      busy_q    <= (state_d != ST_IDLE);
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_a     = addr_q;
  assign mem_wd    = wd_q;
  assign mem_wmask = wmask_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: single I read, stalled D write, reset in
// WAIT, spurious gnt/rvalid in IDLE, and back-to-back conflicting requests
// (expected owner order follows MEM_ARB_RR_EN).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk;
  logic                reset;
  logic                i_req;
  logic [ADDR_W-1:0]   i_addr;
  logic                i_ack;
  logic [DATA_W-1:0]   i_rdata;
  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wd;
  logic [DATA_W/8-1:0] d_wmask;
  logic                d_ack;
  logic [DATA_W-1:0]   d_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_a;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rd;
  logic                busy;

  int n_total;
  int n_bad;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_wmask(d_wmask), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rd(mem_rd), .busy(busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_d;
    logic [DATA_W-1:0] rd_v;
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    i_req      = 1'b0;
    i_addr     = 32'h0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = 32'h0;
    d_wd       = 32'h0;
    d_wmask    = 4'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rd     = 32'h0;
    do_reset();

    // Reset state.
    chk("rst_busy",    {63'd0, busy},    64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_i_ack",   {63'd0, i_ack},   64'd0);
    chk("rst_d_ack",   {63'd0, d_ack},   64'd0);
    chk("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
    chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);
    chk("rst_mem_a",   {32'd0, mem_a},   64'd0);
    chk("rst_mem_wd",  {32'd0, mem_wd},  64'd0);
    chk("rst_mem_wm",  {60'd0, mem_wmask}, 64'd0);
    chk("rst_mem_we",  {63'd0, mem_we},  64'd0);

    // Single I read at minimum latency.
    i_req  = 1'b1;
    i_addr = 32'h100;
    tick();                                   // cycle 1: ISSUE
    chk("i1_mem_req", {63'd0, mem_req}, 64'd1);
    chk("i1_mem_a",   {32'd0, mem_a},   64'h100);
    chk("i1_mem_we",  {63'd0, mem_we},  64'd0);
    chk("i1_mem_wm",  {60'd0, mem_wmask}, 64'd0);
    chk("i1_busy",    {63'd0, busy},    64'd1);
    chk("i1_i_ack",   {63'd0, i_ack},   64'd0);
    mem_gnt = 1'b1;
    tick();                                   // cycle 2: WAIT
    mem_gnt = 1'b0;
    chk("i2_mem_req", {63'd0, mem_req}, 64'd0);
    chk("i2_i_ack",   {63'd0, i_ack},   64'd0);
    mem_rvalid = 1'b1;
    mem_rd     = 32'hDEADBEEF;
    tick();                                   // cycle 3: RESP
    mem_rvalid = 1'b0;
    mem_rd     = 32'h0;
    chk("i3_i_ack",   {63'd0, i_ack},   64'd1);
    chk("i3_i_rdata", {32'd0, i_rdata}, 64'hDEADBEEF);
    chk("i3_d_ack",   {63'd0, d_ack},   64'd0);
    i_req = 1'b0;
    tick();                                   // cycle 4: IDLE
    chk("i4_i_ack",   {63'd0, i_ack},   64'd0);
    chk("i4_busy",    {63'd0, busy},    64'd0);
    chk("i4_i_rdata", {32'd0, i_rdata}, 64'hDEADBEEF);

    // D write with four stall cycles on gnt.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_wd    = 32'h55AA55AA;
    d_wmask = 4'h3;
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk("w_mem_req", {63'd0, mem_req}, 64'd1);
      chk("w_mem_we",  {63'd0, mem_we},  64'd1);
      chk("w_mem_a",   {32'd0, mem_a},   64'h2000);
      chk("w_mem_wd",  {32'd0, mem_wd},  64'h55AA55AA);
      chk("w_mem_wm",  {60'd0, mem_wmask}, 64'h3);
      chk("w_d_ack",   {63'd0, d_ack},   64'd0);
      if (k == 5) begin
        mem_gnt = 1'b1;
      end
      tick();
    end
    mem_gnt = 1'b0;
    chk("w_wait_req", {63'd0, mem_req}, 64'd0);
    chk("w_wait_ack", {63'd0, d_ack},   64'd0);
    mem_rvalid = 1'b1;
    mem_rd     = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("w_d_ack1",   {63'd0, d_ack},   64'd1);
    chk("w_d_rdata",  {32'd0, d_rdata}, 64'h12345678);
    chk("w_i_ack",    {63'd0, i_ack},   64'd0);
    chk("w_i_hold",   {32'd0, i_rdata}, 64'hDEADBEEF);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk("w_d_ack0",   {63'd0, d_ack},   64'd0);
    chk("w_busy0",    {63'd0, busy},    64'd0);

    // Spurious gnt/rvalid while idle.
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rd     = 32'hCAFEF00D;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("sp_busy",    {63'd0, busy},    64'd0);
    chk("sp_mem_req", {63'd0, mem_req}, 64'd0);
    tick();
    chk("sp_i_ack",   {63'd0, i_ack},   64'd0);
    chk("sp_d_ack",   {63'd0, d_ack},   64'd0);
    chk("sp_busy2",   {63'd0, busy},    64'd0);
    chk("sp_d_rdata", {32'd0, d_rdata}, 64'h12345678);

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    i_req  = 1'b1;
    i_addr = 32'h180;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rw_in_wait", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 1'b0;
    chk("rw_busy",    {63'd0, busy},    64'd0);
    chk("rw_mem_a",   {32'd0, mem_a},   64'd0);
    mem_rvalid = 1'b1;
    mem_rd     = 32'hBADBAD00;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_i_ack",   {63'd0, i_ack},   64'd0);
    chk("rw_busy2",   {63'd0, busy},    64'd0);
    chk("rw_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rw_i_rdata", {32'd0, i_rdata}, 64'd0);
    chk("rw_d_rdata", {32'd0, d_rdata}, 64'd0);
    tick();
    chk("rw_i_ack2",  {63'd0, i_ack},   64'd0);

    // Both ports request continuously for four transactions after reset.
    do_reset();
    i_req   = 1'b1;
    i_addr  = 32'h300;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h400;
    d_wd    = 32'h0;
    d_wmask = 4'h0;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      rd_v = 32'hA0000000 + 32'(t);
      for (int w = 0; w < 10 && !mem_req; w++) begin
        chk("cf_no_iack", {63'd0, i_ack & ~exp_d}, 64'd0);
        tick();
      end
      chk("cf_mem_req", {63'd0, mem_req}, 64'd1);
      chk("cf_owner",   {32'd0, mem_a},   exp_d ? 64'h400 : 64'h300);
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rd     = rd_v;
      tick();
      mem_rvalid = 1'b0;
      chk("cf_i_ack", {63'd0, i_ack}, {63'd0, ~exp_d});
      chk("cf_d_ack", {63'd0, d_ack}, {63'd0, exp_d});
      chk("cf_rdata", {32'd0, exp_d ? d_rdata : i_rdata}, {32'd0, rd_v});
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    chk("cf_end_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
